// File: rtl/multicycle_control_unit_if.sv
// Datapath control bundle for multicycle_control_unit.
// The controller drives the strobes and debug state (master); the datapath
// supplies the opcode field, ALU zero flag and memory handshake (slave).
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned STATE_W  = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                byte_en;
  logic [1:0]          pc_src;
  logic [1:0]          reg_dst;
  logic [1:0]          mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                instr_done;
  logic                illegal;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, byte_en,
           pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, byte_en,
           pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer for the CSE-331 datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back and
// drives datapath strobes combinationally from the current state.
// Optional feature macro: MCU_ILLEGAL_TRAP_EN -- when defined, an illegal
// opcode parks the FSM in TRAP with illegal=1 until reset; otherwise TRAP
// retires the opcode as a one-cycle NOP.
module multicycle_control_unit (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_unit_if.master bus
);
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned STATE_W  = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_PASS = ALUOP_W'(5);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

  state_e state_q, state_d;
  logic   run_q;

  logic [OPCODE_W-1:0] op;
  assign op = bus.opcode;

  // run_q holds the controller quiet for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  assign bus.state = state_q;

  // Next-state and datapath strobes; everything idles at 0 until running
  always_comb begin
    state_d        = state_q;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.byte_en    = 1'b0;
    bus.pc_src     = 2'b00;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_ADD;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write  = 1'b1;
            bus.pc_write  = 1'b1;
            bus.alu_src_b = 2'b01;
            state_d       = S_DECODE;
          end
        end

        S_DECODE: begin
          // Precompute the branch target into ALUOut
          bus.alu_src_b = 2'b11;
          case (op)
            6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: state_d = S_EXEC_R;
            6'h06:                                    state_d = S_JR;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C:        state_d = S_EXEC_I;
            6'h10, 6'h11, 6'h12, 6'h13:               state_d = S_MEM_ADDR;
            6'h18, 6'h19:                             state_d = S_BRANCH;
            6'h1A, 6'h1B:                             state_d = S_JUMP;
            default:                                  state_d = S_TRAP;
          endcase
        end

        S_EXEC_R: begin
          bus.alu_src_a = 1'b1;
          case (op)
            6'h01:   bus.alu_op = ALU_SUB;
            6'h02:   bus.alu_op = ALU_AND;
            6'h03:   bus.alu_op = ALU_OR;
            6'h04:   bus.alu_op = ALU_SLT;
            6'h05:   bus.alu_op = ALU_PASS;
            default: bus.alu_op = ALU_ADD;
          endcase
          state_d = S_ALU_WB;
        end

        S_EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          case (op)
            6'h09:   bus.alu_op = ALU_SUB;
            6'h0A:   bus.alu_op = ALU_AND;
            6'h0B:   bus.alu_op = ALU_OR;
            6'h0C:   bus.alu_op = ALU_SLT;
            default: bus.alu_op = ALU_ADD;
          endcase
          state_d = S_ALU_WB;
        end

        S_ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = (op <= 6'h05) ? 2'b01 : 2'b00;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end

        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_d       = (op == 6'h11 || op == 6'h13) ? S_MEM_WR : S_MEM_RD;
        end

        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          bus.byte_en  = (op == 6'h12);
          if (bus.mem_ready) state_d = S_MEM_WB;
        end

        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b01;
          bus.byte_en    = (op == 6'h12);
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end

        S_MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          bus.byte_en   = (op == 6'h13);
          if (bus.mem_ready) begin
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
        end

        S_BRANCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_op     = ALU_SUB;
          bus.pc_src     = 2'b01;
          bus.pc_write   = ((op == 6'h18) && bus.zero) || ((op == 6'h19) && !bus.zero);
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end

        S_JUMP: begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
          if (op == 6'h1B) begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 2'b10;
            bus.mem_to_reg = 2'b10;
          end
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end

        S_JR: begin
          bus.pc_write   = 1'b1;
          bus.pc_src     = 2'b11;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end

        S_TRAP: begin
`ifdef MCU_ILLEGAL_TRAP_EN
          bus.illegal = 1'b1;
          state_d     = S_TRAP;
`else
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
`endif
        end

        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: random instruction stream
// plus directed cases, compared cycle by cycle against an expected-cycle queue.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(3), .STATE_W(4)) bus ();

  multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic       pcw, irw, rw, mr, mw, iord, be;
    logic [1:0] pcs, rd, m2r;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] aop;
    logic       done, ill;
  } outs_t;

  typedef struct {
    int         st;
    logic       rdy;
    logic [5:0] op;
    logic       z;
    outs_t      o;
  } cyc_t;

  cyc_t q[$];
  int checks = 0;
  int passed = 0;

  outs_t obs;
  assign obs = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.i_or_d, bus.byte_en, bus.pc_src, bus.reg_dst,
                bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.instr_done, bus.illegal};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, o, e, $time);
  endtask

  task automatic push(input int st, input logic rdy, input logic [5:0] op,
                      input logic z, input outs_t o);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.op = op; c.z = z; c.o = o;
    q.push_back(c);
  endtask

  // ALU code named by the opcode map (R and I forms share the operation)
  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'h00, 6'h08: return 3'd0;
      6'h01, 6'h09: return 3'd1;
      6'h02, 6'h0A: return 3'd2;
      6'h03, 6'h0B: return 3'd3;
      6'h04, 6'h0C: return 3'd4;
      default:      return 3'd5;
    endcase
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction
  task automatic plan(input logic [5:0] op, input logic z, input int fw,
                      input int mw, input int trap_hold);
    outs_t o;
    logic  ld, st, ldb, stb;
    ld  = (op == 6'h10) || (op == 6'h12);
    st  = (op == 6'h11) || (op == 6'h13);
    ldb = (op == 6'h12);
    stb = (op == 6'h13);
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mr = 1'b1; push(0, 1'b0, op, z, o);
    end
    o = '0; o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.sb = 2'b01;
    push(0, 1'b1, op, z, o);
    o = '0; o.sb = 2'b11; push(1, 1'($urandom), op, z, o);
    if (op <= 6'h05 || (op >= 6'h08 && op <= 6'h0C)) begin
      o = '0; o.sa = 1'b1; o.aop = alu_of(op);
      o.sb = (op <= 6'h05) ? 2'b00 : 2'b10;
      push((op <= 6'h05) ? 2 : 3, 1'($urandom), op, z, o);
      o = '0; o.rw = 1'b1; o.done = 1'b1; o.rd = (op <= 6'h05) ? 2'b01 : 2'b00;
      push(4, 1'($urandom), op, z, o);
    end else if (ld || st) begin
      o = '0; o.sa = 1'b1; o.sb = 2'b10; push(5, 1'($urandom), op, z, o);
      for (int i = 0; i <= mw; i++) begin
        o = '0; o.iord = 1'b1;
        if (ld) begin o.mr = 1'b1; o.be = ldb; end
        else begin o.mw = 1'b1; o.be = stb; o.done = (i == mw); end
        push(ld ? 6 : 8, (i == mw), op, z, o);
      end
      if (ld) begin
        o = '0; o.rw = 1'b1; o.m2r = 2'b01; o.be = ldb; o.done = 1'b1;
        push(7, 1'($urandom), op, z, o);
      end
    end else if (op == 6'h18 || op == 6'h19) begin
      o = '0; o.sa = 1'b1; o.aop = 3'd1; o.pcs = 2'b01; o.done = 1'b1;
      o.pcw = (op == 6'h18) ? z : !z;
      push(9, 1'($urandom), op, z, o);
    end else if (op == 6'h1A || op == 6'h1B) begin
      o = '0; o.pcw = 1'b1; o.pcs = 2'b10; o.done = 1'b1;
      if (op == 6'h1B) begin o.rw = 1'b1; o.rd = 2'b10; o.m2r = 2'b10; end
      push(10, 1'($urandom), op, z, o);
    end else if (op == 6'h06) begin
      o = '0; o.pcw = 1'b1; o.pcs = 2'b11; o.done = 1'b1;
      push(11, 1'($urandom), op, z, o);
    end else begin
`ifdef MCU_ILLEGAL_TRAP_EN
      for (int i = 0; i < trap_hold; i++) begin
        o = '0; o.ill = 1'b1; push(15, 1'($urandom), op, z, o);
      end
`else
      o = '0; o.done = 1'b1; push(15, 1'($urandom), op, z, o);
`endif
    end
  endtask

  // Play n expected cycles (all if n<0): drive on negedge, check 1ns later
  task automatic run(input int n);
    cyc_t c;
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      c = q.pop_front();
      @(negedge clk);
      bus.opcode = c.op; bus.zero = c.z; bus.mem_ready = c.rdy;
      #1;
      chk($sformatf("state op%0h", c.op), 32'(bus.state), 32'(c.st));
      chk($sformatf("outs op%0h st%0d", c.op, c.st), 32'(obs), 32'(c.o));
      k++;
    end
  endtask

  task automatic exec(input logic [5:0] op, input logic z, input int fw, input int mw);
    plan(op, z, fw, mw, 3);
    run(-1);
  endtask

  // Assert reset asynchronously, hold, release at negedge; still quiet that cycle
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst outs", 32'(obs), 32'd0);
    chk("rst state", 32'(bus.state), 32'd0);
    repeat (2) begin
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      chk("rst hold outs", 32'(obs), 32'd0);
      chk("rst hold state", 32'(bus.state), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst release outs", 32'(obs), 32'd0);
    chk("rst release state", 32'(bus.state), 32'd0);
  endtask

  logic [5:0] legal [20] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                             6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h10, 6'h11,
                             6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
  logic [5:0] bad [4] = '{6'h07, 6'h0D, 6'h20, 6'h3F};

  initial begin
    bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    do_reset();

    // Directed cases
    exec(6'h00, 1'b0, 0, 0);   // add: 0,1,2,4
    exec(6'h10, 1'b0, 0, 2);   // lw with two MEM_RD waits
    exec(6'h12, 1'b0, 1, 0);   // lb with a fetch wait
    exec(6'h18, 1'b1, 0, 0);   // beq taken
    exec(6'h19, 1'b1, 0, 0);   // bne not taken
    exec(6'h19, 1'b0, 0, 0);   // bne taken
    exec(6'h1B, 1'b0, 0, 0);   // jal
    exec(6'h13, 1'b0, 0, 1);   // sb with one wait
    exec(6'h06, 1'b0, 0, 0);   // jr
    exec(6'h05, 1'b0, 0, 0);   // move

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = legal[$urandom_range(0, 19)];
`ifndef MCU_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) op = bad[$urandom_range(0, 3)];
`endif
      exec(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a stalled store: write strobe drops at once
    plan(6'h11, 1'b0, 0, 3, 0);
    run(4);
    q.delete();
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk("mid sw state", 32'(bus.state), 32'd8);
    chk("mid sw mem_write", 32'(bus.mem_write), 32'd1);
    do_reset();
    exec(6'h0B, 1'b0, 0, 0);   // ori after recovery

    // Illegal opcode 3F
    exec(6'h3F, 1'b0, 0, 0);
`ifdef MCU_ILLEGAL_TRAP_EN
    do_reset();
`endif
    exec(6'h01, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
